aes128_inv_key_schedule: RTL and testbench
==========================================

Name: aes128_inv_key_schedule

Overview:
- Reverse AES-128 key expansion for the decryption datapath.
- Takes the final (round 10) round key and walks the schedule backwards.
- Emits round keys 10, 9, …, 0 in order on a valid/ready stream, so the inverse-round pipeline can consume them as decryption proceeds.
- Complements the forward round-key generator: same word ordering, same RotWord convention, and the existing Sub_Bytes #(WORD) instance for SubWord (1-cycle registered latency, valid passthrough).

Parameters:
- KEY_L, 128, key / round-key width (only 128 supported)
- WORD, 32, word width; key is 4 words, w0 = bits [127:96]
- NR, 10, number of rounds; first emitted round index

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- start  input  1  request a schedule walk; sampled only when busy=0
- last_key  input  KEY_L  round-NR key; captured on an accepted start
- busy  output  1  high from the cycle after an accepted start until the cycle done pulses
- key_out  output  KEY_L  current round key
- key_round  output  4  round index of key_out (NR down to 0)
- valid_out  output  1  key_out/key_round valid
- ready_in  input  1  consumer ready; transfer occurs on valid_out & ready_in at a clk edge
- done  output  1  one-cycle pulse after the round-0 key transfers

Behaviour:
- Reset (asynchronous, active-low) clears everything:
  - busy=0, valid_out=0, done=0, key_out=0, key_round=0, state=IDLE.
  - Applies immediately, mid-walk included; Sub_Bytes is reset by the same signal.
  - After reset release the block is in IDLE. No partial key is emitted.
- States: IDLE, EMIT, SUB, WAIT.
- IDLE:
  - start=1 at an edge → key_out<=last_key, key_round<=NR, valid_out<=1, busy<=1, go to EMIT.
  - start=0 → stay in IDLE.
- Any start while busy=1 is ignored; last_key is not re-sampled.
- EMIT:
  - valid_out=1; key_out and key_round are held stable while ready_in=0, with no limit on the stall.
  - Transfer with key_round>0 → valid_out<=0, go to SUB.
  - Transfer with key_round=0 → valid_out<=0, busy<=0, done<=1 for one cycle, go to IDLE.
- SUB:
  - With the current key as words w0..w3, combinationally compute p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - Drive Sub_Bytes with valid_in=1 and data RotWord(p3)={p3[23:0],p3[31:24]}.
  - Register p1..p3. Go to WAIT.
- WAIT:
  - Sub_Bytes valid_out is high. Compute p0 = w0 ^ SubWord ^ Rcon(key_round).
  - key_out<={p0,p1,p2,p3}, key_round<=key_round-1, valid_out<=1, go to EMIT.
  - If Sub_Bytes valid_out is not high in WAIT, that is a design error; assert in simulation.
- Rcon(r) = {rc,24'h0} with rc by r=1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. Implemented as an internal case on key_round; r=0 is never used.
- Throughput with ready_in held high: one key every 3 cycles.
  - valid_out is high in cycle S+1 (S = accepted-start edge).
  - valid_out then drops for exactly 2 cycles between keys.
  - 11 keys are transferred and done pulses at cycle S+32.
- done and start in the same cycle: start is ignored, because busy is still high in the done cycle.
- Outputs are registered only; there are no combinational paths from ready_in or start to any output.
- key_out keeps the round-0 key after done until the next accepted start or reset.

Test Plan:
- FIPS-197 A.1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start, ready_in=1 → 11 transfers:
  - round 10 = last_key
  - round 9 = ac7766f319fadc2128d12941575c006e
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - done pulses exactly once at S+32; busy is low the following cycle.
- Backpressure: same vector with ready_in random (about 50%) and held low for 20 cycles at round 5 → key_out/key_round stable while stalled, identical key sequence, no dropped or duplicated rounds.
- Start while busy: a second start with a different last_key at round 7 → ignored, sequence unchanged. A start in the done cycle is also ignored; a start the cycle after done is accepted.
- Reset mid-walk: assert reset in a WAIT cycle → all outputs 0 immediately. After release, a new start with the all-zero key gives round 10 = b4ef5bcb3e92e21123e951cf6f8f188e and round 0 = 00000000000000000000000000000000.
- Cross-check: random cipher keys expanded by a reference model, feeding its round-10 key → the emitted keys match that model's rounds 10..0 over 1000 iterations.

Source files
------------

// File: rtl/aes128_inv_key_schedule_if.sv
// Stream/handshake bundle for the reverse AES-128 key schedule.
// master: the side that requests a walk and consumes round keys.
// slave : the key-schedule block itself.
interface aes128_inv_key_schedule_if #(
  parameter int KEY_L = 128
);
  logic             start;
  logic [KEY_L-1:0] last_key;
  logic             busy;
  logic [KEY_L-1:0] key_out;
  logic [3:0]       key_round;
  logic             valid_out;
  logic             ready_in;
  logic             done;

  modport master (
    output start, last_key, ready_in,
    input  busy, key_out, key_round, valid_out, done
  );

  modport slave (
    input  start, last_key, ready_in,
    output busy, key_out, key_round, valid_out, done
  );
endinterface

// File: rtl/aes128_inv_key_schedule.sv
// Reverse AES-128 key expansion: starting from the round-10 key, emits
// round keys 10 down to 0 on a valid/ready stream. SubWord goes through
// the shared Sub_Bytes stage (one registered cycle, valid passthrough).

// Byte-wise AES S-box over a word, registered, with valid passthrough.
module Sub_Bytes #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [WORD-1:0] data_in,
  output logic            valid_out,
  output logic [WORD-1:0] data_out
);
  logic [WORD-1:0] sub_s;
  logic [WORD-1:0] data_r;
  logic            valid_r;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box: multiplicative inverse as x^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Substitute every byte of the incoming word.
  always_comb begin
    sub_s = '0;
    for (int b = 0; b < WORD / 8; b++) begin
      sub_s[8*b +: 8] = sbox(data_in[8*b +: 8]);
    end
  end

  // Register substituted word and its valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      data_r  <= sub_s;
      valid_r <= valid_in;
    end
  end

  assign data_out  = data_r;
  assign valid_out = valid_r;
endmodule

// SubWord result must be present whenever the schedule sits in WAIT.
module aes128_inv_key_schedule_chk (
  input logic clk,
  input logic reset,
  input logic in_wait,
  input logic sub_valid
);
  a_sub_valid_in_wait: assert property (@(posedge clk) disable iff (!reset) in_wait |-> sub_valid);
endmodule

module aes128_inv_key_schedule #(
  parameter int KEY_L = 128,
  parameter int WORD  = 32,
  parameter int NR    = 10
) (
  input logic                         clk,
  input logic                         reset,
  aes128_inv_key_schedule_if.slave    ks
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]        state_r;
  logic [KEY_L-1:0]  key_r;
  logic [3:0]        round_r;
  logic              valid_r;
  logic              busy_r;
  logic              done_r;
  logic [3*WORD-1:0] p_r;       // {p1, p2, p3} of the next (earlier) round key

  logic [WORD-1:0]   w0_s, w1_s, w2_s, w3_s;
  logic [WORD-1:0]   p0_s, p1_s, p2_s, p3_s;
  logic [WORD-1:0]   rot_s;
  logic [WORD-1:0]   rcon_s;
  logic [WORD-1:0]   sb_data_s;
  logic              sb_valid_s;
  logic              sb_go_s;

  // Round constant for the round that produced the current key.
  function automatic logic [WORD-1:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, {(WORD-8){1'b0}}};
  endfunction

  // Undo the forward XOR chain: words 1..3 of the previous key need no SubWord.
  always_comb begin
    w0_s    = key_r[4*WORD-1 -: WORD];
    w1_s    = key_r[3*WORD-1 -: WORD];
    w2_s    = key_r[2*WORD-1 -: WORD];
    w3_s    = key_r[WORD-1 -: WORD];
    p3_s    = w3_s ^ w2_s;
    p2_s    = w2_s ^ w1_s;
    p1_s    = w1_s ^ w0_s;
    rot_s   = {p3_s[WORD-9:0], p3_s[WORD-1 -: 8]};
    rcon_s  = rcon(round_r);
    p0_s    = w0_s ^ sb_data_s ^ rcon_s;
    sb_go_s = (state_r == S_SUB);
  end

  Sub_Bytes #(.WORD(WORD)) u_sub_bytes (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (sb_go_s),
    .data_in   (rot_s),
    .valid_out (sb_valid_s),
    .data_out  (sb_data_s)
  );

  aes128_inv_key_schedule_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .in_wait   (state_r == S_WAIT),
    .sub_valid (sb_valid_s)
  );

  // Walk controller: capture, emit under backpressure, step one round back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      key_r   <= '0;
      round_r <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      p_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          // busy is still high during the done cycle, so a start there is dropped
          if (busy_r) begin
            busy_r <= 1'b0;
          end else if (ks.start) begin
            key_r   <= ks.last_key;
            round_r <= 4'(NR);
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (ks.ready_in) begin
            valid_r <= 1'b0;
            if (round_r == 4'd0) begin
              done_r  <= 1'b1;
              state_r <= S_IDLE;
            end else begin
              state_r <= S_SUB;
            end
          end
        end
        S_SUB: begin
          p_r     <= {p1_s, p2_s, p3_s};
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (sb_valid_s) begin
            key_r   <= {p0_s, p_r};
            round_r <= round_r - 4'd1;
            valid_r <= 1'b1;
            state_r <= S_EMIT;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign ks.busy      = busy_r;
  assign ks.key_out   = key_r;
  assign ks.key_round = round_r;
  assign ks.valid_out = valid_r;
  assign ks.done      = done_r;
endmodule

// File: tb/tb_aes128_inv_key_schedule.sv
// Self-checking bench for aes128_inv_key_schedule: fixed vectors, corner
// sequences and random keys against a forward key-expansion model.
module tb_aes128_inv_key_schedule;
  logic clk;
  logic reset;

  aes128_inv_key_schedule_if #(.KEY_L(128)) ks();

  aes128_inv_key_schedule #(.KEY_L(128), .WORD(32), .NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .ks    (ks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    int           rnd;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_key [$];
  int           got_rnd [$];
  int done_cnt, done_cyc, vpat_err, stall_bad, timeout;
  logic busy_after, acc_ok;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int prod;
    prod = 0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (32'h11b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward FIPS-197 expansion of a cipher key into round keys 0..10.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic int seq_errs();
    int e;
    if (got_key.size() != 11) return 99;
    e = 0;
    for (int j = 0; j < 11; j++) begin
      if (got_key[j] !== exp_rk[10-j]) e++;
      if (got_rnd[j] != 10 - j) e++;
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ks.start = 1'b0;
    ks.ready_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Run one walk; collects transferred keys and timing observations.
  task automatic walk(input logic [127:0] k, input bit rnd_ready, input int stall_round,
                      input bit busy_start, input bit done_start);
    int stall_left, dc;
    logic [127:0] snap_k;
    logic [3:0]   snap_r;
    bit injected;
    got_key.delete(); got_rnd.delete();
    done_cnt = 0; done_cyc = -1; vpat_err = 0; stall_bad = 0; timeout = 0;
    busy_after = 1'b1; acc_ok = 1'b0;
    stall_left = 20; dc = -1; injected = 0; snap_k = '0; snap_r = 4'd0;
    @(negedge clk);
    ks.start = 1'b1;
    ks.last_key = k;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      ks.start = 1'b0;
      if (dc >= 0 && cyc == dc + 2) begin
        acc_ok = ks.busy && ks.valid_out && (ks.key_round == 4'd10) && (ks.key_out == ~k);
        break;
      end
      if (dc >= 0 && cyc == dc + 1) begin
        busy_after = ks.busy;
        if (!done_start) break;
        ks.start = 1'b1;
      end
      if (ks.done) begin
        done_cnt++;
        if (dc < 0) begin dc = cyc; done_cyc = cyc; end
        if (done_start) begin ks.start = 1'b1; ks.last_key = ~k; end
      end
      if (cyc <= 31 && ks.valid_out != ((cyc - 1) % 3 == 0)) vpat_err++;
      ks.ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ks.valid_out && int'(ks.key_round) == stall_round && stall_left > 0) begin
        if (stall_left == 20) begin
          snap_k = ks.key_out; snap_r = ks.key_round;
        end else if (ks.key_out !== snap_k || ks.key_round !== snap_r) begin
          stall_bad++;
        end
        ks.ready_in = 1'b0;
        stall_left--;
      end
      if (busy_start && !injected && ks.valid_out && ks.key_round == 4'd7) begin
        ks.start = 1'b1; ks.last_key = ~k; injected = 1;
      end
      if (ks.valid_out && ks.ready_in) begin
        got_key.push_back(ks.key_out);
        got_rnd.push_back(int'(ks.key_round));
      end
    end
    if (dc < 0) timeout = 1;
  endtask

  vec_t tbl [7];
  int   j;

  initial begin
    tbl[0] = '{FIPS_K10, 10, FIPS_K10};
    tbl[1] = '{FIPS_K10,  9, 128'hac7766f319fadc2128d12941575c006e};
    tbl[2] = '{FIPS_K10,  1, 128'ha0fafe1788542cb123a339392a6c7605};
    tbl[3] = '{FIPS_K10,  0, FIPS_K0};
    tbl[4] = '{ZERO_K10, 10, ZERO_K10};
    tbl[5] = '{ZERO_K10,  1, 128'h62636363626363636263636362636363};
    tbl[6] = '{ZERO_K10,  0, 128'h0};

    build_sbox();
    reset = 1'b0;
    ks.start = 1'b0;
    ks.last_key = '0;
    ks.ready_in = 1'b0;

    // Reset state
    #12;
    check("rst_busy", 128'(ks.busy), 128'd0);
    check("rst_valid", 128'(ks.valid_out), 128'd0);
    check("rst_done", 128'(ks.done), 128'd0);
    check("rst_key", ks.key_out, 128'd0);
    check("rst_round", 128'(ks.key_round), 128'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", 128'(ks.valid_out), 128'd0);

    // Table vectors, ready held high
    for (int i = 0; i < 7; i++) begin
      walk(tbl[i].key, 1'b0, -1, 1'b0, 1'b0);
      check("tbl_timeout", 128'(timeout), 128'd0);
      check("tbl_count", 128'(got_key.size()), 128'd11);
      j = 10 - tbl[i].rnd;
      if (j < got_key.size()) begin
        check($sformatf("tbl%0d_key_r%0d", i, tbl[i].rnd), got_key[j], tbl[i].exp);
        check($sformatf("tbl%0d_round", i), 128'(got_rnd[j]), 128'(tbl[i].rnd));
      end
      check("done_cycle", 128'(done_cyc), 128'd32);
      check("done_once", 128'(done_cnt), 128'd1);
      check("busy_after_done", 128'(busy_after), 128'd0);
      check("valid_pattern", 128'(vpat_err), 128'd0);
    end

    // Backpressure with a 20-cycle stall at round 5
    expand(FIPS_K0);
    walk(FIPS_K10, 1'b1, 5, 1'b0, 1'b0);
    check("bp_timeout", 128'(timeout), 128'd0);
    check("bp_sequence", 128'(seq_errs()), 128'd0);
    check("bp_stall_stable", 128'(stall_bad), 128'd0);
    check("bp_done_once", 128'(done_cnt), 128'd1);

    // Start while busy is ignored
    walk(FIPS_K10, 1'b0, -1, 1'b1, 1'b0);
    check("busy_start_sequence", 128'(seq_errs()), 128'd0);
    check("busy_start_done_cycle", 128'(done_cyc), 128'd32);

    // Start in the done cycle ignored, accepted one cycle later
    walk(FIPS_K10, 1'b0, -1, 1'b0, 1'b1);
    check("done_start_ignored", 128'(busy_after), 128'd0);
    check("after_done_start_accepted", 128'(acc_ok), 128'd1);
    do_reset();

    // Reset asserted in a WAIT cycle
    @(negedge clk);
    ks.start = 1'b1; ks.last_key = FIPS_K10; ks.ready_in = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      ks.start = 1'b0;
    end
    check("wait_cycle_busy", 128'(ks.busy), 128'd1);
    reset = 1'b0;
    #1;
    check("midrst_busy", 128'(ks.busy), 128'd0);
    check("midrst_valid", 128'(ks.valid_out), 128'd0);
    check("midrst_key", ks.key_out, 128'd0);
    check("midrst_round", 128'(ks.key_round), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    expand(128'h0);
    walk(ZERO_K10, 1'b0, -1, 1'b0, 1'b0);
    check("zero_sequence", 128'(seq_errs()), 128'd0);
    if (got_key.size() == 11) begin
      check("zero_r10", got_key[0], ZERO_K10);
      check("zero_r0", got_key[10], 128'h0);
    end

    // Random cipher keys against the forward model
    for (int it = 0; it < 1000; it++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      walk(exp_rk[10], (it % 8) == 0, -1, 1'b0, 1'b0);
      check($sformatf("rand%0d_sequence", it), 128'(seq_errs() + timeout + (done_cnt != 1)), 128'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
